// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t     : responder FSM states (IDLE, WAIT, RESP)
//   SZ_*        : RISC-V load/store funct3 size encodings
//   size_bytes  : access width in bytes for a funct3 code (111 treated as d)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BU: size_bytes = 4'd1;
      SZ_H, SZ_HU: size_bytes = 4'd2;
      SZ_W, SZ_WU: size_bytes = 4'd4;
      default:     size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational byte-lane logic for one 64-bit storage word.
// The byte offset is first aligned down to the access size, then:
//   rdata  : addressed lane shifted to bit 0, sign- or zero-extended per size
//   merged : word with the low bytes of wdata written into the addressed lane
// Ports:
//   word   in  64  current storage word
//   offset in  3   byte offset within the word
//   size   in  3   funct3 size code
//   wdata  in  64  right-aligned store data
//   rdata  out 64  extended load value
//   merged out 64  word after a store of this size at this offset
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  logic [2:0]  size,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic [63:0] merged
);

  logic [3:0]  nbytes;
  logic [2:0]  off_al;
  logic [5:0]  shamt;
  logic [63:0] lane;
  logic [63:0] mask;

  always_comb begin
    nbytes = size_bytes(size);
    // For 8-byte accesses nbytes[2:0] is 0, so the mask becomes 0 and the
    // offset collapses to 0 as well.
    off_al = offset & ~(nbytes[2:0] - 3'd1);
    shamt  = {off_al, 3'b000};
    lane   = word >> shamt;

    case (nbytes)
      4'd1:    mask = 64'h0000_0000_0000_00FF;
      4'd2:    mask = 64'h0000_0000_0000_FFFF;
      4'd4:    mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = '1;
    endcase

    case (size)
      SZ_B:    rdata = {{56{lane[7]}},  lane[7:0]};
      SZ_H:    rdata = {{48{lane[15]}}, lane[15:0]};
      SZ_W:    rdata = {{32{lane[31]}}, lane[31:0]};
      SZ_BU:   rdata = {56'd0, lane[7:0]};
      SZ_HU:   rdata = {48'd0, lane[15:0]};
      SZ_WU:   rdata = {32'd0, lane[31:0]};
      default: rdata = lane;
    endcase

    merged = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder for MEM-stage load/store requests backed by on-chip word storage.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, and is answered
// with a one-cycle resp_valid pulse in RESP. Stores are read-modify-write and
// commit on the edge leaving RESP.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to add the err port, which
// flags misaligned accesses (store suppressed, load data 0). Without it,
// misaligned offsets are silently aligned down to the access size.
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   asynchronous active-low reset
//   req_valid  in  1   request present
//   req_ready  out 1   responder idle and able to accept
//   req_we     in  1   1 = store, 0 = load
//   req_addr   in  64  byte address (wraps modulo DEPTH*8)
//   req_wdata  in  64  right-aligned store data
//   req_size   in  3   funct3 size code
//   resp_valid out 1   one-cycle response pulse
//   resp_rdata out 64  load result (0 for stores), held until next response
//   stall      out 1   pipeline hold while a request is outstanding
//   err        out 1   misaligned flag with resp_valid (optional feature only)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        stall
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state;
  state_t             state_next;
  logic [3:0]         cnt;
  logic               lat_we;
  logic [IDX_W-1:0]   lat_idx;
  logic [2:0]         lat_off;
  logic [2:0]         lat_size;
  logic [63:0]        lat_wdata;
  logic [63:0]        rdata_hold;

  logic [63:0]        mem [DEPTH];
  logic [63:0]        word;
  logic [63:0]        lane_rdata;
  logic [63:0]        lane_merged;
  logic [63:0]        resp_data;
  logic               wr_ok;

  // Address bits above the word index are deliberately ignored (wrap).
  logic               addr_unused;
  assign addr_unused = &{1'b0, req_addr[63:IDX_W+3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_idx    <= '0;
      lat_off    <= '0;
      lat_size   <= '0;
      lat_wdata  <= '0;
      rdata_hold <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_idx   <= req_addr[3 +: IDX_W];
        lat_off   <= req_addr[2:0];
        lat_size  <= req_size;
        lat_wdata <= req_wdata;
        cnt       <= 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RESP) begin
        rdata_hold <= resp_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign stall      = (state == IDLE && req_valid) || (state == WAIT);

  // Storage has no reset; an aborted request never reaches RESP, so it is
  // never written.
  always_ff @(posedge clk) begin
    if (state == RESP && lat_we && wr_ok) begin
      mem[lat_idx] <= lane_merged;
    end
  end

  assign word = mem[lat_idx];

  dmem_lane u_lane (
    .word   (word),
    .offset (lat_off),
    .size   (lat_size),
    .wdata  (lat_wdata),
    .rdata  (lane_rdata),
    .merged (lane_merged)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic [3:0] off_mask;
  logic       misal;
  assign off_mask = size_bytes(lat_size) - 4'd1;
  assign misal    = ({1'b0, lat_off} & off_mask) != 4'd0;
  assign wr_ok    = !misal;
  assign err      = (state == RESP) && misal;
`else
  assign wr_ok = 1'b1;
`endif

  assign resp_data  = (lat_we || !wr_ok) ? '0 : lane_rdata;
  assign resp_rdata = (state == RESP) ? resp_data : rdata_hold;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and LATENCY=0) share the
// request bus; each has its own req_valid. Expected responses are queued at
// issue time and consumed by a negedge monitor that also tracks the expected
// handshake timing of each instance.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [2:0]  size;
  logic        rdy_a, rv_a, stl_a, er_a;
  logic        rdy_b, rv_b, stl_b, er_b;
  logic [63:0] rd_a, rd_b;

  exp_t        q_a[$];
  exp_t        q_b[$];
  bit          pend [2];
  int          cnt  [2];
  logic [63:0] last [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy_a), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_size(size), .resp_valid(rv_a),
    .resp_rdata(rd_a), .stall(stl_a)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .err(er_a)
`endif
  );

  dmem_responder #(.DEPTH(256), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy_b), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .req_size(size), .resp_valid(rv_b),
    .resp_rdata(rd_b), .stall(stl_b)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .err(er_b)
`endif
  );

`ifndef DMEM_MISALIGN_TRAP_EN
  assign er_a = 1'b0;
  assign er_b = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic mon(input int w, input int lat, input logic rv, input logic rdy,
                     input logic stl, input logic er, input logic v, input logic [63:0] rd);
    string t;
    logic  exp_rv;
    logic  exp_er;
    exp_t  e;
    t = (w == 0) ? "a" : "b";
    if (!rst) begin
      pend[w] = 1'b0;
      cnt[w]  = 0;
      last[w] = '0;
      chk({t, "_rst_ctl"}, 64'({rv, rdy, stl, er}), 64'b0100);
      chk({t, "_rst_rdata"}, rd, 64'd0);
    end else begin
      if (pend[w]) cnt[w]++;
      exp_rv = pend[w] && (cnt[w] == lat + 1);
      exp_er = 1'b0;
      e = '{64'd0, 1'b0};
      if (exp_rv) begin
        if (w == 0 && q_a.size() > 0) e = q_a.pop_front();
        else if (w == 1 && q_b.size() > 0) e = q_b.pop_front();
        else begin
          checks++;
          errors++;
          $display("FAIL %s_no_expectation actual=response required=none", t);
        end
        exp_er = e.err;
      end
      chk({t, "_ctl(rv,rdy,stall,err)"}, 64'({rv, rdy, stl, er}),
          64'({exp_rv, !pend[w], (v && !pend[w]) || (pend[w] && !exp_rv), exp_er}));
      if (exp_rv) begin
        chk({t, "_rdata"}, rd, e.rdata);
        last[w] = e.rdata;
        pend[w] = 1'b0;
      end else begin
        chk({t, "_rdata_hold"}, rd, last[w]);
        if (!pend[w] && v) begin
          pend[w] = 1'b1;
          cnt[w]  = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, LAT_A, rv_a, rdy_a, stl_a, er_a, vld[0], rd_a);
    mon(1, LAT_B, rv_b, rdy_b, stl_b, er_b, vld[1], rd_b);
  end

  task automatic wait_idle(input int w);
    int n = 0;
    while (((w == 0) ? rdy_a : rdy_b) !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout_%0d actual=0 required=1", w);
    end
  endtask

  task automatic issue(input int w, input logic w_e, input logic [63:0] a,
                       input logic [63:0] d, input logic [2:0] s,
                       input logic [63:0] exp_rd, input logic exp_err);
    wait_idle(w);
    we = w_e; addr = a; wdata = d; size = s;
    vld[w] = 1'b1;
    if (w == 0) q_a.push_back('{exp_rd, exp_err});
    else        q_b.push_back('{exp_rd, exp_err});
    @(posedge clk); #1;
    vld[w] = 1'b0;
    // Disturb the bus after acceptance; the latched request must be used.
    we = ~w_e; addr = ~a; wdata = ~d; size = s ^ 3'b111;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; vld = 2'b00; we = 1'b0; addr = '0; wdata = '0; size = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Known value in word 2, then a store to it aborted by reset in WAIT.
    issue(0, 1'b1, 64'h10, 64'hDEADBEEF_0BADF00D, SZ_D, 64'd0, 1'b0);
    wait_idle(0);
    we = 1'b1; addr = 64'h10; wdata = 64'h5555_5555_5555_5555; size = SZ_D;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    issue(0, 1'b0, 64'h10, 64'd0, SZ_D, 64'hDEADBEEF_0BADF00D, 1'b0);

    // Store then load, LATENCY=2.
    issue(0, 1'b1, 64'h08, 64'h11223344_55667788, SZ_D, 64'd0, 1'b0);
    issue(0, 1'b0, 64'h08, 64'd0, SZ_D, 64'h11223344_55667788, 1'b0);

    // Sub-word loads from word 0 = 0x00000000_8000FF80.
    issue(0, 1'b1, 64'h00, 64'h00000000_8000FF80, SZ_D, 64'd0, 1'b0);
    issue(0, 1'b0, 64'h00, 64'd0, SZ_B,  64'hFFFFFFFF_FFFFFF80, 1'b0);
    issue(0, 1'b0, 64'h00, 64'd0, SZ_BU, 64'h00000000_00000080, 1'b0);
    issue(0, 1'b0, 64'h01, 64'd0, SZ_B,  64'hFFFFFFFF_FFFFFFFF, 1'b0);
    issue(0, 1'b0, 64'h02, 64'd0, SZ_H,  64'hFFFFFFFF_FFFF8000, 1'b0);
    issue(0, 1'b0, 64'h02, 64'd0, SZ_HU, 64'h00000000_00008000, 1'b0);
    issue(0, 1'b0, 64'h00, 64'd0, SZ_W,  64'hFFFFFFFF_8000FF80, 1'b0);
    issue(0, 1'b0, 64'h00, 64'd0, SZ_WU, 64'h00000000_8000FF80, 1'b0);
    issue(0, 1'b0, 64'h00, 64'd0, 3'b111, 64'h00000000_8000FF80, 1'b0);

    // Partial store merge into word 1.
    issue(0, 1'b1, 64'h08, 64'hAAAAAAAA_AAAAAAAA, SZ_D, 64'd0, 1'b0);
    issue(0, 1'b1, 64'h0C, 64'hFFFFFFFF_FFFF1234, SZ_H, 64'd0, 1'b0);
    issue(0, 1'b0, 64'h08, 64'd0, SZ_D, 64'hAAAA1234_AAAAAAAA, 1'b0);
    issue(0, 1'b1, 64'h0F, 64'hFFFFFFFF_FFFFFF77, SZ_B, 64'd0, 1'b0);
    issue(0, 1'b0, 64'h08, 64'd0, SZ_D, 64'h77AA1234_AAAAAAAA, 1'b0);

    // Misaligned accesses: trapped with the option, aligned down without.
    issue(0, 1'b0, 64'h03, 64'd0, SZ_H,
          TRAP ? 64'd0 : 64'hFFFFFFFF_FFFF8000, TRAP);
    issue(0, 1'b1, 64'h06, 64'h00000000_12345678, SZ_W, 64'd0, TRAP);
    issue(0, 1'b0, 64'h00, 64'd0, SZ_D,
          TRAP ? 64'h00000000_8000FF80 : 64'h12345678_8000FF80, 1'b0);

    // LATENCY=0 instance: back-to-back traffic and address wrap.
    issue(1, 1'b1, 64'h808, 64'h01234567_89ABCDEF, SZ_D, 64'd0, 1'b0);
    issue(1, 1'b0, 64'h008, 64'd0, SZ_D, 64'h01234567_89ABCDEF, 1'b0);
    issue(1, 1'b0, 64'h808, 64'd0, SZ_D, 64'h01234567_89ABCDEF, 1'b0);
    issue(1, 1'b0, 64'h80F, 64'd0, SZ_BU, 64'h00000000_00000001, 1'b0);
    issue(1, 1'b0, 64'h00C, 64'd0, SZ_W,  64'h00000000_01234567, 1'b0);
    issue(1, 1'b0, 64'h008, 64'd0, SZ_B,  64'hFFFFFFFF_FFFFFFEF, 1'b0);

    n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_outstanding", 64'(q_a.size() + q_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
